// File: rtl/vga_rx_monitor.sv
// vga_rx_monitor
// Recovers the pixel position of a VGA stream from its sync pulses, checks
// the hs/vs timing against the expected geometry, and once several clean
// frames have been seen, presents the visible pixels with their coordinates.
// Every output comes from one register stage fed by the S1 input sample, so
// all outputs share the same latency from the pins.
module vga_rx_monitor #(
  parameter int H_ACTIVE    = 800,
  parameter int H_TOTAL     = 1040,
  parameter int HS_START    = 856,
  parameter int HS_WIDTH    = 120,
  parameter int V_ACTIVE    = 600,
  parameter int V_TOTAL     = 666,
  parameter int VS_START    = 637,
  parameter int VS_WIDTH    = 7,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vga_hs,
  input  logic        vga_vs,
  input  logic [2:0]  vga_RGB,
  output logic        pix_valid,
  output logic [10:0] pix_x,
  output logic [9:0]  pix_y,
  output logic [2:0]  pix_rgb,
  output logic        frame_start,
  output logic        locked,
  output logic        err_h,
  output logic        err_v,
  output logic        err_blank,
  output logic [15:0] frame_cnt
);

  localparam logic [10:0] X_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] X_ACTIVE = 11'(H_ACTIVE);
  localparam logic [10:0] X_HS_ON  = 11'(HS_START);
  localparam logic [10:0] X_HS_OFF = 11'(HS_START + HS_WIDTH);
  localparam logic [9:0]  Y_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]  Y_ACTIVE = 10'(V_ACTIVE);
  localparam logic [9:0]  Y_VS_ON  = 10'(VS_START);
  localparam logic [9:0]  Y_VS_OFF = 10'(VS_START + VS_WIDTH);

  // Good-frame counter is wide enough to hold LOCK_FRAMES itself.
  localparam int              GW        = $clog2(LOCK_FRAMES + 1) + 1;
  localparam logic [GW-1:0]   GOOD_LOCK = GW'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    SEARCH,
    H_ALIGNED,
    V_ALIGNED,
    LOCKED
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic            s1_hs, s1_vs, s2_hs, s2_vs;
  logic [2:0]      s1_rgb;
  logic [10:0]     pos_x;
  logic [9:0]      pos_y;
  logic [GW-1:0]   good_cnt;
  logic [GW-1:0]   good_nx;

  logic            hs_rise, hs_fall, vs_rise, vs_fall;
  logic [10:0]     cur_x, x_nx;
  logic [9:0]      cur_y, y_nx;
  logic            h_err, v_err;
  logic            in_active, show, blank_bad, frame_tick;

  // Position of the S1 sample: the free-running counter, snapped to the
  // sync positions when the tracker first aligns to hs and then to vs.
  always_comb begin
    hs_rise = s1_hs & ~s2_hs;
    hs_fall = ~s1_hs & s2_hs;
    vs_rise = s1_vs & ~s2_vs;
    vs_fall = ~s1_vs & s2_vs;

    cur_x = pos_x;
    if (state == SEARCH && hs_rise) begin
      cur_x = X_HS_ON;
    end
    cur_y = pos_y;
    if (state == H_ALIGNED && vs_rise && cur_x == 11'd0) begin
      cur_y = Y_VS_ON;
    end

    if (cur_x == X_LAST) begin
      x_nx = 11'd0;
      y_nx = (cur_y == Y_LAST) ? 10'd0 : cur_y + 10'd1;
    end else begin
      x_nx = cur_x + 11'd1;
      y_nx = cur_y;
    end
  end

  // Sync checks and tracker state transitions for the S1 sample.
  always_comb begin
    h_err    = 1'b0;
    v_err    = 1'b0;
    state_nx = state;
    good_nx  = good_cnt;

    if (state != SEARCH) begin
      h_err = (hs_rise && cur_x != X_HS_ON) || (hs_fall && cur_x != X_HS_OFF);
    end
    if (state == H_ALIGNED) begin
      v_err = vs_rise && cur_x != 11'd0;
    end else if (state == V_ALIGNED || state == LOCKED) begin
      v_err = (vs_rise && (cur_x != 11'd0 || cur_y != Y_VS_ON)) ||
              (vs_fall && (cur_x != 11'd0 || cur_y != Y_VS_OFF));
    end

    case (state)
      SEARCH: begin
        if (hs_rise) state_nx = H_ALIGNED;
      end
      H_ALIGNED: begin
        if (h_err || v_err) begin
          state_nx = SEARCH;
        end else if (vs_rise) begin
          state_nx = V_ALIGNED;
          good_nx  = '0;
        end
      end
      V_ALIGNED: begin
        if (h_err || v_err) begin
          state_nx = SEARCH;
        end else if (vs_rise) begin
          good_nx = good_cnt + GW'(1);
          if (good_nx == GOOD_LOCK) state_nx = LOCKED;
        end
      end
      LOCKED: begin
        if (h_err || v_err) state_nx = SEARCH;
      end
      default: state_nx = SEARCH;
    endcase

    in_active  = (cur_x < X_ACTIVE) && (cur_y < Y_ACTIVE);
    show       = (state_nx == LOCKED) && in_active;
    blank_bad  = (state_nx == LOCKED) && !in_active && (s1_rgb != 3'd0);
    frame_tick = (state == LOCKED) && vs_rise;
  end

  // Input pipeline, tracker state and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_hs       <= 1'b0;
      s1_vs       <= 1'b0;
      s1_rgb      <= 3'd0;
      s2_hs       <= 1'b0;
      s2_vs       <= 1'b0;
      pos_x       <= 11'd0;
      pos_y       <= 10'd0;
      good_cnt    <= '0;
      state       <= SEARCH;
      locked      <= 1'b0;
      pix_valid   <= 1'b0;
      pix_x       <= 11'd0;
      pix_y       <= 10'd0;
      pix_rgb     <= 3'd0;
      frame_start <= 1'b0;
      err_h       <= 1'b0;
      err_v       <= 1'b0;
      err_blank   <= 1'b0;
      frame_cnt   <= 16'd0;
    end else begin
      s1_hs       <= vga_hs;
      s1_vs       <= vga_vs;
      s1_rgb      <= vga_RGB;
      s2_hs       <= s1_hs;
      s2_vs       <= s1_vs;
      pos_x       <= x_nx;
      pos_y       <= y_nx;
      good_cnt    <= good_nx;
      state       <= state_nx;
      locked      <= (state_nx == LOCKED);
      pix_valid   <= show;
      pix_x       <= show ? cur_x : 11'd0;
      pix_y       <= show ? cur_y : 10'd0;
      pix_rgb     <= show ? s1_rgb : 3'd0;
      frame_start <= show && cur_x == 11'd0 && cur_y == 10'd0;
      err_h       <= h_err;
      err_v       <= v_err;
      err_blank   <= blank_bad;
      frame_cnt   <= frame_cnt + 16'(frame_tick);
    end
  end

endmodule

// File: doc/vga_rx_monitor.md
VGA_RX_MONITOR -- requirements
Module: vga_rx_monitor

Interface
REQ-001 Parameter H_ACTIVE, 800, visible pixels per line.
REQ-002 Parameter H_TOTAL, 1040, clocks per line.
REQ-003 Parameter HS_START, 856, x of first hs-high sample.
REQ-004 Parameter HS_WIDTH, 120, hs-high samples per line.
REQ-005 Parameter V_ACTIVE, 600, visible lines per frame.
REQ-006 Parameter V_TOTAL, 666, lines per frame.
REQ-007 Parameter VS_START, 637, y of first vs-high line.
REQ-008 Parameter VS_WIDTH, 7, vs-high lines per frame.
REQ-009 Parameter LOCK_FRAMES, 2, clean frames required before lock.
REQ-010 clk  in  1  pixel clock, same as the VGA source clock; clock clk.
REQ-011 rst  in  1  reset rst, synchronous, active-high.
REQ-012 vga_hs, vga_vs  in  1 each  sync inputs, active-high pulses.
REQ-013 vga_RGB  in  3  pixel colour.
REQ-014 pix_valid  out  1  visible pixel present on pix_x/pix_y/pix_rgb.
REQ-015 pix_x  out  11; pix_y  out  10; pix_rgb  out  3  recovered pixel coordinates and colour.
REQ-016 frame_start  out  1  one-cycle pulse with the pixel (0,0) while locked.
REQ-017 locked  out  1  timing tracked and verified.
REQ-018 err_h, err_v, err_blank  out  1 each  one-cycle error pulses.
REQ-019 frame_cnt  out  16  completed locked frames, wraps.

Function
REQ-020 Inputs SHALL be registered once (stage S1); edges SHALL be detected between S1 and a second register S2; each S1 sample SHALL be assigned a position (x,y).
REQ-021 x SHALL increment per sample and wrap H_TOTAL-1 -> 0; y SHALL increment on x wrap and wrap V_TOTAL-1 -> 0.
REQ-022 States: SEARCH, H_ALIGNED, V_ALIGNED, LOCKED.
REQ-023 SEARCH: on hs rise, the sample SHALL be assigned x=HS_START; go to H_ALIGNED; no error checks are made.
REQ-024 H_ALIGNED: on vs rise at x==0, the sample SHALL be assigned y=VS_START, good-frame counter cleared, go to V_ALIGNED; a vs rise at x!=0 SHALL pulse err_v and return to SEARCH.
REQ-025 In H_ALIGNED, V_ALIGNED and LOCKED, an hs rise at x!=HS_START or an hs fall at x!=HS_START+HS_WIDTH SHALL pulse err_h and return to SEARCH.
REQ-026 In V_ALIGNED and LOCKED, a vs rise at (x,y)!=(0,VS_START) or a vs fall at (x,y)!=(0,VS_START+VS_WIDTH) SHALL pulse err_v and return to SEARCH.
REQ-027 V_ALIGNED: each error-free vs rise SHALL increment the good-frame counter; when it reaches LOCK_FRAMES, go to LOCKED.
REQ-028 If h and v errors occur in the same cycle, both pulses SHALL assert; leaving LOCKED SHALL clear locked in the same cycle as the error pulse.
REQ-029 locked SHALL be 1 exactly while in LOCKED.
REQ-030 While locked, a sample with x>=H_ACTIVE or y>=V_ACTIVE and vga_RGB!=0 SHALL pulse err_blank; err_blank SHALL NOT change state.
REQ-031 pix_valid SHALL be 1 when locked, x<H_ACTIVE and y<V_ACTIVE; pix_x/pix_y/pix_rgb then carry that sample; otherwise pix_* SHALL be 0.
REQ-032 pix_*, frame_start and err_* SHALL appear 2 clocks after the pin sample, with a fixed latency for all outputs.
REQ-033 frame_cnt SHALL increment at each vs rise while in LOCKED and wrap 65535 -> 0; it SHALL hold otherwise.

Reset
REQ-034 While rst=1, the block SHALL go to SEARCH and clear S1, S2, x, y and the good-frame counter; all outputs SHALL read 0 on the cycle after rst is sampled high.
REQ-035 A reset mid-frame SHALL force full reacquisition: an hs align, a vs align, then LOCK_FRAMES clean frames.

Verification
REQ-036 Drive nominal 1040x666 timing with hs=1 at x 856..975 and vs=1 at y 637..643 -> locked rises at the 3rd vs rise (LOCK_FRAMES=2); 480000 pix_valid per frame; no err_*.
REQ-037 Locked; delay one hs rise by 1 clock -> err_h pulses once, locked=0 the same cycle, relock after 2 further clean frames.
REQ-038 Locked; vga_RGB=3'b101 at x=900,y=10 -> a single err_blank pulse; locked stays 1; no pix_valid for that sample.
REQ-039 Locked; shorten the vs pulse to 6 lines -> err_v at the vs fall, (x,y)=(0,643); state returns to SEARCH.
REQ-040 Locked; assert rst for 1 clock at y=300 -> all outputs 0 the next cycle; frame_cnt=0.
REQ-041 Preload frame_cnt to 65535 via a long run or a forced value -> the next locked vs rise gives frame_cnt=0.
